pkt_extractor: RTL and testbench
================================

PKT_EXTRACTOR -- requirements
Module: pkt_extractor

Interface
REQ-001 The block SHALL have parameter PKT_LEN, default 12, giving the number of payload bytes per packet (range 1..64).
REQ-002 The block SHALL have parameter SOF, default 8'hA5, giving the start-of-frame byte value.
REQ-003 The block SHALL have parameter USE_CHK, default 1; 1 means a trailing checksum byte follows the payload, 0 means no checksum.
REQ-004 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum number of clock cycles allowed between consecutive bytes inside a frame (≥2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rx_data, input, 8 bits: byte from the UART receiver.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-009 The block SHALL have port pkt_data, output, PKT_LEN*8 bits: assembled payload, first received byte in bits [7:0].
REQ-010 The block SHALL have port pkt_valid, output, 1 bit: pkt_data holds a complete, checked packet.
REQ-011 The block SHALL have port pkt_ready, input, 1 bit: consumer accepts the packet.
REQ-012 The block SHALL have ports err_chk, err_timeout and err_ovf, each an output of 1 bit: single-cycle error pulses.

Function
REQ-013 The block SHALL implement the states IDLE, PAYLOAD, CHECK and HOLD.
- IDLE: ignore every byte except SOF.
- rx_valid with rx_data==SOF: enter PAYLOAD; clear the byte index and the running sum.
REQ-014 In PAYLOAD, each rx_valid SHALL write rx_data into byte slot [index], add it to the running sum (8-bit, wrapping modulo 256) and increment index.
- No SOF detection in PAYLOAD; SOF-valued bytes are ordinary data.
REQ-015 On the byte that fills slot PKT_LEN-1, the block SHALL enter CHECK if USE_CHK=1, otherwise HOLD.
REQ-016 In CHECK, the next rx_valid byte SHALL be compared with the running sum.
- Equal: enter HOLD.
- Unequal: pulse err_chk for one cycle, return to IDLE, never assert pkt_valid.
REQ-017 pkt_valid SHALL assert in the cycle after the rx_valid cycle of the completing byte (checksum byte, or last payload byte when USE_CHK=0); latency is exactly 1 cycle.
REQ-018 In HOLD, pkt_valid and pkt_data SHALL be held stable until a cycle with pkt_valid&&pkt_ready; the next state SHALL be IDLE, with pkt_valid low in the following cycle.
REQ-019 An rx_valid during HOLD SHALL be dropped and SHALL pulse err_ovf.
- Exception: if pkt_ready is high in the same cycle, the byte SHALL be processed as in IDLE (a SOF starts a new frame).
REQ-020 A cycle counter SHALL run in PAYLOAD and CHECK, cleared on every rx_valid and on entry.
- On reaching TIMEOUT with no rx_valid: pulse err_timeout, return to IDLE, discard the partial frame.
- rx_valid in the same cycle the count reaches TIMEOUT: the byte wins, no timeout.
REQ-021 pkt_data slots not yet written in the current frame SHALL retain their previous values; only pkt_valid qualifies the data.
REQ-022 Error pulses SHALL be registered, one cycle wide, and mutually exclusive in any cycle.

Reset
REQ-023 Asserting rst_n low SHALL immediately set the state to IDLE and clear index, sum, timeout counter, pkt_data (all zero), pkt_valid, err_chk, err_timeout and err_ovf, regardless of clk.
REQ-024 Reset asserted mid-frame or in HOLD SHALL discard the frame; after release the block SHALL require a fresh SOF.
REQ-025 The first rx_valid SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (PKT_LEN=4, USE_CHK=1, TIMEOUT=16, SOF=A5)
REQ-026 Bytes A5,01,02,03,04,0A with pkt_ready=1 -> pkt_valid for one cycle, 1 cycle after byte 0A, pkt_data=32'h04030201, no error pulses.
REQ-027 Bytes A5,10,20,30,40,00 -> err_chk pulse one cycle after 00; pkt_valid stays 0; a following valid frame is accepted normally.
REQ-028 Bytes A5,01,02, then 16 idle cycles -> err_timeout pulse, state IDLE; next bytes 03,04 ignored; no pkt_valid.
REQ-029 Valid frame with pkt_ready=0, then byte 55 arrives -> err_ovf pulse; pkt_data stays 04030201 until pkt_ready=1, then pkt_valid drops the next cycle.
REQ-030 rst_n driven low after A5,01,02 -> all outputs 0 immediately; after release, bytes 03,04,0A,A5 do not produce a packet until a full new frame arrives.
REQ-031 Bytes 00,FF,A5,A5,A5,A5,A5,D9 -> leading 00,FF ignored; pkt_data=32'hA5A5A5A5 accepted (sum 0x94 mismatches D9) -> err_chk; repeat with checksum 94 -> pkt_valid.

Source files
------------

// File: rtl/pkt_extractor.sv
// rtl/pkt_extractor.sv - UART byte-stream packet extractor with SOF sync, checksum and inter-byte timeout
module pkt_extractor #(
    parameter int unsigned PKT_LEN = 12,
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int unsigned USE_CHK = 1,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [PKT_LEN*8-1:0] pkt_data,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic                 err_ovf
);
    localparam int unsigned       IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        slot_q [PKT_LEN];
    logic              valid_q;
    logic              err_chk_q;
    logic              err_to_q;
    logic              err_ovf_q;

    // A byte accepted in HOLD together with pkt_ready is treated as if the block were idle.
    logic sof_seen;
    assign sof_seen = rx_valid && (rx_data == SOF) &&
                      ((state_q == IDLE) || ((state_q == HOLD) && pkt_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovf_q <= 1'b0;
            for (int i = 0; i < PKT_LEN; i++) slot_q[i] <= '0;
        end else begin
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovf_q <= 1'b0;
            case (state_q)
                IDLE: ;
                PAYLOAD: begin
                    if (rx_valid) begin
                        slot_q[idx_q] <= rx_data;
                        sum_q         <= sum_q + rx_data;
                        idx_q         <= idx_q + 1'b1;
                        cnt_q         <= '0;
                        if (idx_q == LAST_IDX) begin
                            if (USE_CHK != 0) begin
                                state_q <= CHECK;
                            end else begin
                                state_q <= HOLD;
                                valid_q <= 1'b1;
                            end
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_to_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        cnt_q <= '0;
                        if (rx_data == sum_q) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_to_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (rx_valid) begin
                        err_ovf_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (sof_seen) begin
                state_q <= PAYLOAD;
                idx_q   <= '0;
                sum_q   <= '0;
                cnt_q   <= '0;
            end
        end
    end

    for (genvar g = 0; g < PKT_LEN; g++) begin : g_pack
        assign pkt_data[g*8 +: 8] = slot_q[g];
    end

    assign pkt_valid   = valid_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_to_q;
    assign err_ovf     = err_ovf_q;
endmodule

// File: tb/tb_pkt_extractor.sv
// tb/tb_pkt_extractor.sv - self-checking bench for pkt_extractor (PKT_LEN=4, USE_CHK=1, TIMEOUT=16)
module tb_pkt_extractor;
    localparam int   PKT_LEN = 4;
    localparam int   TIMEOUT = 16;
    localparam logic [7:0] SOF = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic        err_chk, err_timeout, err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_extractor #(.PKT_LEN(PKT_LEN), .SOF(SOF), .USE_CHK(1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .err_chk(err_chk), .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of bytes seen since SOF, judged once complete.
    logic [7:0] m_bytes [PKT_LEN];
    int         m_nbytes;
    int         m_gap;
    bit         m_in_frame, m_holding;
    logic       e_valid, e_chk, e_to, e_ovf;

    function automatic logic [31:0] m_data();
        return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    endfunction

    function automatic logic [7:0] m_sum();
        int s = 0;
        for (int i = 0; i < PKT_LEN; i++) s += m_bytes[i];
        return 8'(s % 256);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PKT_LEN; i++) m_bytes[i] = 8'h00;
        m_nbytes = 0; m_gap = 0; m_in_frame = 0; m_holding = 0;
        e_valid = 0; e_chk = 0; e_to = 0; e_ovf = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        bit as_idle = 0;
        e_chk = 0; e_to = 0; e_ovf = 0;
        if (m_holding) begin
            if (r) begin
                m_holding = 0; e_valid = 0; as_idle = 1;
            end else if (v) begin
                e_ovf = 1;
            end
        end else if (!m_in_frame) begin
            as_idle = 1;
        end else if (v) begin
            m_gap = 0;
            if (m_nbytes < PKT_LEN) begin
                m_bytes[m_nbytes] = d;
                m_nbytes++;
            end else begin
                m_in_frame = 0;
                if (d == m_sum()) begin m_holding = 1; e_valid = 1; end
                else e_chk = 1;
            end
        end else begin
            m_gap++;
            if (m_gap >= TIMEOUT) begin m_in_frame = 0; e_to = 1; end
        end
        if (as_idle && v && d == SOF) begin
            m_in_frame = 1; m_nbytes = 0; m_gap = 0;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        check("cyc_valid", {31'd0, pkt_valid}, {31'd0, e_valid});
        check("cyc_data", pkt_data, m_data());
        check("cyc_err_chk", {31'd0, err_chk}, {31'd0, e_chk});
        check("cyc_err_timeout", {31'd0, err_timeout}, {31'd0, e_to});
        check("cyc_err_ovf", {31'd0, err_ovf}, {31'd0, e_ovf});
        if (rst_n) model_step(rx_valid, rx_data, pkt_ready);
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, ck);
        send(SOF); send(b0); send(b1); send(b2); send(b3); send(ck);
    endtask

    initial begin
        @(posedge clk); #1;
        check("reset_valid", {31'd0, pkt_valid}, 32'd0);
        check("reset_data", pkt_data, 32'd0);
        check("reset_errs", {29'd0, err_chk, err_timeout, err_ovf}, 32'd0);
        rst_n = 1'b1;

        // Good frame, consumer always ready
        pkt_ready = 1'b1;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check("good_valid", {31'd0, pkt_valid}, 32'd1);
        check("good_data", pkt_data, 32'h04030201);
        check("good_no_err", {29'd0, err_chk, err_timeout, err_ovf}, 32'd0);
        idle(1);
        check("good_valid_drop", {31'd0, pkt_valid}, 32'd0);

        // Bad checksum, then a normal frame
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h00);
        check("badck_err", {31'd0, err_chk}, 32'd1);
        check("badck_novalid", {31'd0, pkt_valid}, 32'd0);
        idle(1);
        check("badck_pulse_end", {31'd0, err_chk}, 32'd0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check("after_badck_valid", {31'd0, pkt_valid}, 32'd1);
        idle(2);

        // Timeout after a partial frame; trailing bytes ignored
        send(SOF); send(8'h01); send(8'h02);
        idle(15);
        check("to_not_yet", {31'd0, err_timeout}, 32'd0);
        idle(1);
        check("to_pulse", {31'd0, err_timeout}, 32'd1);
        send(8'h03); send(8'h04);
        idle(2);
        check("to_no_pkt", {31'd0, pkt_valid}, 32'd0);

        // Byte arriving on the last allowed cycle beats the timeout
        send(SOF); send(8'h01);
        idle(15);
        send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
        check("to_edge_valid", {31'd0, pkt_valid}, 32'd1);
        idle(2);

        // Overflow while holding, then release
        pkt_ready = 1'b0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        idle(3);
        send(8'h55);
        check("ovf_pulse", {31'd0, err_ovf}, 32'd1);
        check("ovf_data_held", pkt_data, 32'h04030201);
        check("ovf_valid_held", {31'd0, pkt_valid}, 32'd1);
        idle(2);
        pkt_ready = 1'b1;
        idle(1);
        check("ovf_release", {31'd0, pkt_valid}, 32'd0);
        idle(1);

        // Reset mid-frame
        send(SOF); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {28'd0, pkt_valid, err_chk, err_timeout, err_ovf}, 32'd0);
        check("midrst_data", pkt_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h03); send(8'h04); send(8'h0A); send(SOF);
        check("postrst_no_pkt", {31'd0, pkt_valid}, 32'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
        check("postrst_new_frame", {31'd0, pkt_valid}, 32'd1);
        idle(2);

        // Leading junk, SOF-valued payload bytes
        send(8'h00); send(8'hFF);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hD9);
        check("sofdata_err", {31'd0, err_chk}, 32'd1);
        check("sofdata_slots", pkt_data, 32'hA5A5A5A5);
        idle(1);
        send(8'h00); send(8'hFF);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94);
        check("sofdata_valid", {31'd0, pkt_valid}, 32'd1);
        check("sofdata_data", pkt_data, 32'hA5A5A5A5);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
